// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: FSM state encoding and default parameters for pipeline_ctrl
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, JMP_PEND = 2'd1, TRAP_DRAIN = 2'd2, TRAP_ACK = 2'd3} state_t;
  localparam int DEF_STALL_LIMIT = 64;
  localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping
// ports: clk, rst (async, active-low), en (count this cycle), q (count value)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/flow controller producing flush, stall and memory-freeze controls
// ports: clk, rst (async, active-low); decode read-valid, exec jump, imem/dmem wait and trap
// request inputs; trap_ack, flush_front, flush_all, stall, mem_wait, hang_err and the
// saturating stall_cnt / flush_cnt statistics outputs
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic             dec_a_rvalid,
  input  logic             dec_b_rvalid,
  input  logic             exec_jmp,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  input  logic             trap_req,
  output logic             trap_ack,
  output logic             flush_front,
  output logic             flush_all,
  output logic             stall,
  output logic             mem_wait,
  output logic             hang_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int RW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] LIM = RW'(STALL_LIMIT);
  state_t state, state_nx;
  logic trap_take, jmp_flush;
  logic [RW-1:0] run;
  // every control except mem_wait is gated by rst so it reads 0 while reset is held
  always_comb begin
    mem_wait = imem_wait | dmem_wait;
    trap_take = rst && trap_req && (state == RUN || state == JMP_PEND);
    jmp_flush = rst && !trap_take && !mem_wait && (state == JMP_PEND || (state == RUN && exec_jmp));
    flush_all = trap_take || (rst && (state == TRAP_DRAIN || state == TRAP_ACK));
    flush_front = flush_all || jmp_flush;
    stall = rst && state == RUN && !trap_req && !exec_jmp && !mem_wait && dec_valid && !(dec_a_rvalid && dec_b_rvalid);
    trap_ack = rst && state == TRAP_ACK;
    state_nx = trap_take ? TRAP_DRAIN
             : state == RUN ? (exec_jmp && mem_wait ? JMP_PEND : RUN)
             : state == JMP_PEND ? (mem_wait ? JMP_PEND : RUN)
             : state == TRAP_DRAIN ? (dmem_wait ? TRAP_DRAIN : TRAP_ACK) : RUN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      run <= '0;
      hang_err <= 1'b0;
    end else begin
      state <= state_nx;
      run <= !stall ? '0 : run == LIM ? run : run + 1'b1;
      hang_err <= hang_err || run == LIM;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .en(stall), .q(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .en(jmp_flush), .q(flush_cnt));
endmodule
